writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 119 +++++++++++
 tb/tb_writeback_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// In-order register-file writeback queue with optional pending-write forwarding.
// Define WRITEBACK_QUEUE_FORWARD_EN to enable the lookup/forwarding comparators.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     resultValid,
  output logic                     resultReady,
  input  logic [4:0]               resultAddress,
  input  logic [31:0]              resultData,
  input  logic                     writeStall,
  output logic                     writeEnable3,
  output logic [4:0]               writeAddress3,
  output logic [31:0]              writeData3,
  input  logic [4:0]               lookupAddress1,
  input  logic [4:0]               lookupAddress2,
  output logic                     pendingHit1,
  output logic                     pendingHit2,
  output logic [31:0]              pendingData1,
  output logic [31:0]              pendingData2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic             push_s, alloc_s, pop_s, has_head_s;

  // Handshake and write-port outputs; ready is forced low while reset is held.
  always_comb begin
    has_head_s    = (count_q != {CW{1'b0}});
    resultReady   = resetN && (count_q < CW'(DEPTH));
    writeEnable3  = has_head_s && !writeStall;
    writeAddress3 = has_head_s ? addr_q[rd_ptr_q] : 5'd0;
    writeData3    = has_head_s ? data_q[rd_ptr_q] : 32'd0;
    count         = count_q;
  end

  // Next-state: x0 results complete the handshake but never take an entry.
  always_comb begin
    push_s   = resultValid && resultReady;
    alloc_s  = push_s && (resultAddress != 5'd0);
    pop_s    = writeEnable3;
    rd_ptr_d = pop_s   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = alloc_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(alloc_s) - CW'(pop_s);
    valid_d  = (valid_q & ~(DEPTH'(pop_s) << rd_ptr_q)) | (DEPTH'(alloc_s) << wr_ptr_q);
  end

  // State registers; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      valid_q  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      if (alloc_s) begin
        addr_q[wr_ptr_q] <= resultAddress;
        data_q[wr_ptr_q] <= resultData;
      end else begin
        addr_q[wr_ptr_q] <= addr_q[wr_ptr_q];
        data_q[wr_ptr_q] <= data_q[wr_ptr_q];
      end
    end
  end

`ifdef WRITEBACK_QUEUE_FORWARD_EN
  logic [PW-1:0] idx_s;
  logic          hit1_s, hit2_s;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    idx_s        = {PW{1'b0}};
    hit1_s       = 1'b0;
    hit2_s       = 1'b0;
    pendingHit1  = 1'b0;
    pendingHit2  = 1'b0;
    pendingData1 = 32'd0;
    pendingData2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s        = rd_ptr_q + PW'(i);
      hit1_s       = valid_q[idx_s] && (lookupAddress1 != 5'd0) && (addr_q[idx_s] == lookupAddress1);
      hit2_s       = valid_q[idx_s] && (lookupAddress2 != 5'd0) && (addr_q[idx_s] == lookupAddress2);
      pendingHit1  = pendingHit1 | hit1_s;
      pendingHit2  = pendingHit2 | hit2_s;
      pendingData1 = hit1_s ? data_q[idx_s] : pendingData1;
      pendingData2 = hit2_s ? data_q[idx_s] : pendingData2;
    end
  end
`else
  logic unused_lookup_s;

  // Forwarding disabled: lookup ports are present but ignored.
  always_comb begin
    unused_lookup_s = ^{lookupAddress1, lookupAddress2};
    pendingHit1     = 1'b0;
    pendingHit2     = 1'b0;
    pendingData1    = 32'd0;
    pendingData2    = 32'd0;
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed scoreboard bench for writeback_queue (DEPTH 4); forwarding checks
// follow WRITEBACK_QUEUE_FORWARD_EN.
module tb_writeback_queue;

  logic        clock = 1'b0;
  logic        resetN;
  logic        resultValid;
  logic        resultReady;
  logic [4:0]  resultAddress;
  logic [31:0] resultData;
  logic        writeStall;
  logic        writeEnable3;
  logic [4:0]  writeAddress3;
  logic [31:0] writeData3;
  logic [4:0]  lookupAddress1, lookupAddress2;
  logic        pendingHit1, pendingHit2;
  logic [31:0] pendingData1, pendingData2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q [$];

  writeback_queue #(.DEPTH(4)) dut (
    .clock(clock), .resetN(resetN),
    .resultValid(resultValid), .resultReady(resultReady),
    .resultAddress(resultAddress), .resultData(resultData),
    .writeStall(writeStall),
    .writeEnable3(writeEnable3), .writeAddress3(writeAddress3), .writeData3(writeData3),
    .lookupAddress1(lookupAddress1), .lookupAddress2(lookupAddress2),
    .pendingHit1(pendingHit1), .pendingHit2(pendingHit2),
    .pendingData1(pendingData1), .pendingData2(pendingData2),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    resultValid   = 1'b1;
    resultAddress = a;
    resultData    = d;
    #1;
    chk("ready_at_push", 64'(resultReady), 64'd1);
    if (a != 5'd0) exp_q.push_back({a, d});
    step();
    resultValid   = 1'b0;
    resultAddress = 5'd0;
    resultData    = 32'd0;
  endtask

  task automatic drain();
    writeStall = 1'b0;
    for (int n = 0; n < 40 && count != 3'd0; n++) step();
    chk("drain_count", 64'(count), 64'd0);
  endtask

  // Scoreboard: every write-port beat must match the oldest expected entry.
  always @(negedge clock) begin
    if (resetN === 1'b1 && writeEnable3 === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed %0h_%0h expected none", writeAddress3, writeData3);
      end
      if (exp_q.size() != 0) begin
        logic [36:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({writeAddress3, writeData3} === e) else begin
          errors++;
          $error("FAIL write_order observed %0h_%0h expected %0h_%0h",
                 writeAddress3, writeData3, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int pushed;
    resetN = 1'b0; resultValid = 1'b0; resultAddress = 5'd0; resultData = 32'd0;
    writeStall = 1'b0; lookupAddress1 = 5'd0; lookupAddress2 = 5'd0;
    step(); step();
    // Reset values, with a push request held to prove ready stays low.
    resultValid = 1'b1; resultAddress = 5'd3; resultData = 32'h33;
    #1;
    chk("rst_ready", 64'(resultReady), 64'd0);
    chk("rst_we", 64'(writeEnable3), 64'd0);
    chk("rst_waddr", 64'(writeAddress3), 64'd0);
    chk("rst_wdata", 64'(writeData3), 64'd0);
    chk("rst_hit", 64'({pendingHit1, pendingHit2}), 64'd0);
    chk("rst_pdata", {pendingData1, pendingData2}, 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    resultValid = 1'b0; resultAddress = 5'd0; resultData = 32'd0;
    resetN = 1'b1;
    #1;
    chk("post_rst_ready", 64'(resultReady), 64'd1);

    // Single push, latency one.
    push(5'd1, 32'h19);
    chk("lat_we", 64'(writeEnable3), 64'd1);
    chk("lat_waddr", 64'(writeAddress3), 64'd1);
    chk("lat_wdata", 64'(writeData3), 64'h19);
    step();
    chk("lat_count0", 64'(count), 64'd0);

    // Fill under stall, then a full cycle with a pop must still refuse a push.
    writeStall = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(i + 2), 32'hA0 + 32'(i));
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(resultReady), 64'd0);
    step();
    chk("stall_hold", 64'(count), 64'd4);
    writeStall = 1'b0;
    resultValid = 1'b1; resultAddress = 5'd6; resultData = 32'h66;
    #1;
    chk("full_pop_ready", 64'(resultReady), 64'd0);
    step();
    resultValid = 1'b0; resultAddress = 5'd0; resultData = 32'd0;
    chk("pop_count3", 64'(count), 64'd3);
    for (int i = 2; i >= 0; i--) begin
      step();
      chk("drain_step", 64'(count), 64'(i));
    end

    // Simultaneous push and pop keeps count.
    push(5'd10, 32'h100);
    chk("pp_count1", 64'(count), 64'd1);
    push(5'd11, 32'h101);
    chk("pp_count_same", 64'(count), 64'd1);
    step();
    chk("pp_count0", 64'(count), 64'd0);

    // x0 results are accepted and dropped.
    push(5'd0, 32'hFFFF_FFFF);
    chk("x0_count", 64'(count), 64'd0);
    chk("x0_we", 64'(writeEnable3), 64'd0);
    chk("x0_ready", 64'(resultReady), 64'd1);

    // Forwarding: youngest match wins; non-matching lookup misses.
    writeStall = 1'b1;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    lookupAddress1 = 5'd7; lookupAddress2 = 5'd8;
    #1;
`ifdef WRITEBACK_QUEUE_FORWARD_EN
    chk("fwd_hit1", 64'(pendingHit1), 64'd1);
    chk("fwd_data1", 64'(pendingData1), 64'h22);
`else
    chk("fwd_hit1_off", 64'(pendingHit1), 64'd0);
    chk("fwd_data1_off", 64'(pendingData1), 64'd0);
`endif
    chk("fwd_hit2", 64'(pendingHit2), 64'd0);
    chk("fwd_data2", 64'(pendingData2), 64'd0);
    lookupAddress1 = 5'd0; lookupAddress2 = 5'd0;
    drain();

    // Asynchronous reset mid-cycle discards queued writes.
    writeStall = 1'b1;
    push(5'd12, 32'hC0);
    push(5'd13, 32'hC1);
    push(5'd14, 32'hC2);
    chk("pre_rst_count", 64'(count), 64'd3);
    #1;
    writeStall = 1'b0;
    resetN = 1'b0;
    #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_we", 64'(writeEnable3), 64'd0);
    exp_q.delete();
    #1;
    resetN = 1'b1;
    step(); step(); step();
    chk("postrst_count", 64'(count), 64'd0);

    // Ten pushes with alternating stall, wrapping the pointers.
    pushed = 0;
    for (int cyc = 0; cyc < 100 && pushed < 10; cyc++) begin
      writeStall = cyc[0];
      if (resultReady) begin
        resultValid   = 1'b1;
        resultAddress = 5'(pushed + 1);
        resultData    = 32'hB0 + 32'(pushed);
        exp_q.push_back({5'(pushed + 1), 32'hB0 + 32'(pushed)});
        pushed++;
      end else begin
        resultValid = 1'b0;
      end
      step();
      resultValid = 1'b0;
    end
    chk("wrap_pushed", 64'(pushed), 64'd10);
    drain();
    step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
